ifft_syn: RTL

Inverse-DFT synthesiser for the 16-point FAS datapath. It accepts one frame of 16 complex bins in the FFT output format and turns it back into a serial stream of 16 real time-domain samples, in the same word format the analyser consumes on `data`/`data_valid`. It uses a single time-multiplexed complex×twiddle MAC and takes 17 cycles per sample. It serves as the reconstruction and loop-back end of the FFT path.

---
 rtl/ifft_syn_pkg.sv | 58 +++++
 rtl/ifft_syn_mac.sv | 49 ++++
 rtl/ifft_syn.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ifft_syn_pkg.sv
// Shared constants, twiddle lookup and output scaling for the 16-point
// inverse-DFT synthesiser.
package ifft_syn_pkg;

  localparam int DATA_W = 16;
  localparam int BIN_W  = 32;
  localparam int ACC_W  = 37;
  localparam int N      = 16;

  // Quarter-wave cosine table, signed Q2.14
  localparam logic signed [15:0] TW_M0 = 16'sd16384;
  localparam logic signed [15:0] TW_M1 = 16'sd15137;
  localparam logic signed [15:0] TW_M2 = 16'sd11585;
  localparam logic signed [15:0] TW_M3 = 16'sd6270;
  localparam logic signed [15:0] TW_M4 = 16'sd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  function automatic logic signed [15:0] cos_q14(input logic [3:0] m);
    case (m)
      4'd0:    return TW_M0;
      4'd1:    return TW_M1;
      4'd2:    return TW_M2;
      4'd3:    return TW_M3;
      4'd4:    return TW_M4;
      4'd5:    return -TW_M3;
      4'd6:    return -TW_M2;
      4'd7:    return -TW_M1;
      4'd8:    return -TW_M0;
      4'd9:    return -TW_M1;
      4'd10:   return -TW_M2;
      4'd11:   return -TW_M3;
      4'd12:   return TW_M4;
      4'd13:   return TW_M3;
      4'd14:   return TW_M2;
      4'd15:   return TW_M1;
      default: return 16'sd0;
    endcase
  endfunction

  // Round half up, drop 14 twiddle bits plus the 1/16 scale, then saturate
  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = (a + 37'sd131072) >>> 18;
    if (r > 37'sd32767) begin
      return 16'sd32767;
    end else if (r < -37'sd32768) begin
      return -16'sd32768;
    end else begin
      return r[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/ifft_syn_mac.sv
// Time-multiplexed complex x twiddle multiply-accumulate: acc += Xr*cos(m) - Xi*sin(m).
module ifft_syn_mac
  import ifft_syn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BIN_W-1:0]        bin,
  input  logic [3:0]              m,
  input  logic                    clr,
  input  logic                    en,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [15:0]      xr_s;
  logic signed [15:0]      xi_s;
  logic signed [15:0]      c_s;
  logic signed [15:0]      s_s;
  logic [3:0]              m_sin_s;
  logic signed [31:0]      p_re_s;
  logic signed [31:0]      p_im_s;
  logic signed [ACC_W-1:0] term_s;
  logic signed [ACC_W-1:0] acc_r;

  assign xr_s    = signed'(bin[31:16]);
  assign xi_s    = signed'(bin[15:0]);
  // sin(m) is cos(m - 4), i.e. a quarter-turn back in the 4-bit phase
  assign m_sin_s = m + 4'd12;
  assign c_s     = cos_q14(m);
  assign s_s     = cos_q14(m_sin_s);
  assign p_re_s  = 32'(xr_s) * 32'(c_s);
  assign p_im_s  = 32'(xi_s) * 32'(s_s);
  assign term_s  = ACC_W'(p_re_s) - ACC_W'(p_im_s);

  // Accumulator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= acc_r + term_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/ifft_syn.sv
// 16-point inverse-DFT synthesiser: captures one frame of bins and streams
// 16 real Q8.8 samples, 17 cycles per sample.
module ifft_syn
  import ifft_syn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fft_valid,
  input  logic [BIN_W-1:0]  fft_d0,
  input  logic [BIN_W-1:0]  fft_d1,
  input  logic [BIN_W-1:0]  fft_d2,
  input  logic [BIN_W-1:0]  fft_d3,
  input  logic [BIN_W-1:0]  fft_d4,
  input  logic [BIN_W-1:0]  fft_d5,
  input  logic [BIN_W-1:0]  fft_d6,
  input  logic [BIN_W-1:0]  fft_d7,
  input  logic [BIN_W-1:0]  fft_d8,
  input  logic [BIN_W-1:0]  fft_d9,
  input  logic [BIN_W-1:0]  fft_d10,
  input  logic [BIN_W-1:0]  fft_d11,
  input  logic [BIN_W-1:0]  fft_d12,
  input  logic [BIN_W-1:0]  fft_d13,
  input  logic [BIN_W-1:0]  fft_d14,
  input  logic [BIN_W-1:0]  fft_d15,
  output logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              frame_done,
  output logic              overrun
);

  logic [BIN_W-1:0]        bins_s  [N];
  logic [BIN_W-1:0]        frame_r [N];
  logic                    fv_q_r;
  logic                    strobe_s;
  state_e                  state_r;
  state_e                  state_nx_s;
  logic                    capture_s;
  logic                    mac_en_s;
  logic                    mac_clr_s;
  logic                    emit_s;
  logic [3:0]              k_r;
  logic [3:0]              n_r;
  logic [3:0]              phase_r;
  logic signed [ACC_W-1:0] acc_s;
  logic signed [DATA_W-1:0] sample_s;
  logic                    ready_r;
  logic [DATA_W-1:0]       data_r;
  logic                    data_valid_r;
  logic                    frame_done_r;
  logic                    overrun_r;

  assign bins_s[0]  = fft_d0;   assign bins_s[1]  = fft_d1;
  assign bins_s[2]  = fft_d2;   assign bins_s[3]  = fft_d3;
  assign bins_s[4]  = fft_d4;   assign bins_s[5]  = fft_d5;
  assign bins_s[6]  = fft_d6;   assign bins_s[7]  = fft_d7;
  assign bins_s[8]  = fft_d8;   assign bins_s[9]  = fft_d9;
  assign bins_s[10] = fft_d10;  assign bins_s[11] = fft_d11;
  assign bins_s[12] = fft_d12;  assign bins_s[13] = fft_d13;
  assign bins_s[14] = fft_d14;  assign bins_s[15] = fft_d15;

  assign strobe_s = fft_valid & ~fv_q_r;

  // Edge-detect delay and FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fv_q_r  <= 1'b0;
      state_r <= ST_IDLE;
    end else begin
      fv_q_r  <= fft_valid;
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: if (strobe_s) state_nx_s = ST_MAC;  else state_nx_s = ST_IDLE;
      ST_MAC:  if (k_r == 4'd15) state_nx_s = ST_EMIT; else state_nx_s = ST_MAC;
      ST_EMIT: if (n_r == 4'd15) state_nx_s = ST_IDLE; else state_nx_s = ST_MAC;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM decoded controls
  always_comb begin
    capture_s = 1'b0;
    mac_en_s  = 1'b0;
    mac_clr_s = 1'b1;
    emit_s    = 1'b0;
    case (state_r)
      ST_IDLE: capture_s = strobe_s;
      ST_MAC: begin
        mac_en_s  = 1'b1;
        mac_clr_s = 1'b0;
      end
      ST_EMIT: emit_s = 1'b1;
      default: capture_s = 1'b0;
    endcase
  end

  // Bin index, sample index and twiddle phase m = n*k mod 16
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_r     <= 4'd0;
      n_r     <= 4'd0;
      phase_r <= 4'd0;
    end else if (capture_s) begin
      k_r     <= 4'd0;
      n_r     <= 4'd0;
      phase_r <= 4'd0;
    end else if (mac_en_s) begin
      k_r     <= k_r + 4'd1;
      phase_r <= phase_r + n_r;
    end else if (emit_s) begin
      k_r     <= 4'd0;
      n_r     <= n_r + 4'd1;
      phase_r <= 4'd0;
    end else begin
      k_r     <= k_r;
      n_r     <= n_r;
      phase_r <= phase_r;
    end
  end

  // Frame register: only loaded by an accepted capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) frame_r[i] <= '0;
    end else if (capture_s) begin
      for (int i = 0; i < N; i++) frame_r[i] <= bins_s[i];
    end else begin
      for (int i = 0; i < N; i++) frame_r[i] <= frame_r[i];
    end
  end

  ifft_syn_mac u_mac (
    .clk (clk),
    .rst (rst),
    .bin (frame_r[k_r]),
    .m   (phase_r),
    .clr (mac_clr_s),
    .en  (mac_en_s),
    .acc (acc_s)
  );

  assign sample_s = round_sat(acc_s);

  // Registered outputs; overrun is sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r      <= 1'b1;
      data_r       <= '0;
      data_valid_r <= 1'b0;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      ready_r      <= (state_r == ST_IDLE);
      data_r       <= emit_s ? sample_s : data_r;
      data_valid_r <= emit_s;
      frame_done_r <= emit_s && (n_r == 4'd15);
      overrun_r    <= overrun_r | (strobe_s && (state_r != ST_IDLE));
    end
  end

  assign ready      = ready_r;
  assign data       = data_r;
  assign data_valid = data_valid_r;
  assign frame_done = frame_done_r;
  assign overrun    = overrun_r;

endmodule
